md_issue: RTL
=============

// Module: md_issue
// PURPOSE
//  EX-stage issue/interlock controller sitting directly upstream of the md multiply/divide unit.
//  Accepts an md-class instruction from the E stage and registers its op and operands toward md.
//  Stalls the pipeline while md is occupied; serves MFHI/MFLO reads from md's hi/lo.
//  Also provides a sticky divide-by-zero flag and a watchdog timeout.
// PARAMETERS
//  OP_W     4   width of md op code (MD_* encodings from md.h)
//  TIMEOUT  15  max cycles in WAIT before timeout fires (md DIV needs 10)
//  CNT_W    4   watchdog counter width; must satisfy 2**CNT_W > TIMEOUT
// PORTS
//  clk          in   1     single clock, all state updates on posedge
//  reset        in   1     synchronous, active-high
//  e_valid      in   1     E-stage instruction valid
//  e_flush      in   1     E-stage instruction being squashed this cycle
//  e_md_op      in   OP_W  MD_NONE/MULT/MULTU/DIV/DIVU/MTHI/MTLO
//  e_mf_hi      in   1     E-stage instruction is MFHI
//  e_mf_lo      in   1     E-stage instruction is MFLO
//  e_rs         in   32    rs operand (-> md dh)
//  e_rt         in   32    rt operand (-> md dl)
//  md_busy      in   1     from md
//  md_invalid   in   1     from md (div by zero of latched op)
//  md_hi        in   32    from md
//  md_lo        in   32    from md
//  md_op        out  OP_W  registered op to md; non-NONE for exactly one cycle per issue
//  md_dh        out  32    registered operand to md
//  md_dl        out  32    registered operand to md
//  stall        out  1     freeze F/D/E; comb
//  mf_data      out  32    md_hi if e_mf_hi, else md_lo if e_mf_lo, else 0; comb
//  div0_sticky  out  1     set on divide-by-zero, held until div0_clr
//  div0_clr     in   1     clears div0_sticky
//  timeout      out  1     sticky, set when watchdog expires; cleared only by reset
// BEHAVIOUR
//  Reset values: state=IDLE; md_op=MD_NONE; md_dh=md_dl=0; div0_sticky=0; timeout=0; watchdog=0.
//  need = e_valid & ~e_flush & (e_md_op!=MD_NONE | e_mf_hi | e_mf_lo).
//  stall = need & (state!=IDLE | md_busy). A flushed instruction never stalls.
//  Accept: state==IDLE & ~md_busy & e_valid & ~e_flush & e_md_op!=MD_NONE.
//   Next posedge: md_op<=e_md_op, md_dh<=e_rs, md_dl<=e_rt, state<=ISSUE. Accepting instruction is not stalled.
//  md samples md_op on the negedge inside the ISSUE cycle; md_op returns to MD_NONE at the following posedge.
//  FSM:
//   IDLE : accept -> ISSUE; md_busy seen without accept -> WAIT (covers md still busy after reset)
//   ISSUE: op was MTHI/MTLO -> IDLE; otherwise -> WAIT
//   WAIT : md_busy==0 -> IDLE; watchdog==TIMEOUT-1 -> IDLE and timeout<=1
//  Watchdog clears on entering WAIT and increments each WAIT cycle. It saturates and does not wrap.
//  Latency: MULT/MULTU issued at posedge N -> ISSUE N..N+1 -> WAIT -> IDLE at N+6. An MFHI in E stalls through N+5.
//  Div0: in the first WAIT cycle of a DIV/DIVU, md_invalid=1 sets div0_sticky. If set and div0_clr coincide, set wins.
//  mf_data is valid only when MFHI/MFLO is unstalled (state IDLE & ~md_busy). With e_mf_hi & e_mf_lo both high, hi wins.
//  Issued ops cannot be cancelled: flush or a later exception leaves ISSUE/WAIT running to completion.
//  Mid-operation reset: FSM goes to IDLE. md has no reset, so a still-busy md forces IDLE->WAIT and stall.
// STRUCTURE
//  MD_* op encodings stay in the shared md.h header; no new encodings are added.
//  FSM state localparams (IDLE=0, ISSUE=1, WAIT=2) are local to this file.
//  One sub-module, md_watchdog: CNT_W counter with clear/enable/expire, reused by later multicycle units.
//  Issue registers, FSM, div0/timeout flags and output muxing stay in md_issue.
// TESTING
//  Pair with real md. Each line: stimulus -> required response.
//  MULT rs=0xFFFFFFFB rt=3, then MFLO/MFHI -> stall for 6 cycles; mf_data=0xFFFFFFF1, then 0xFFFFFFFF.
//  DIVU rs=7 rt=0 -> div0_sticky=1 in first WAIT cycle, hi=lo=0.
//  Then div0_clr with no new div -> div0_sticky=0.
//  MTHI rs=0x12345678, next instr MFHI -> 1-cycle stall, then mf_data=0x12345678.
//  DIV back-to-back with MULT -> MULT stalled until DIV leaves WAIT.
//  md_op non-NONE exactly 2 single-cycle windows.
//  e_flush with MULT in E -> no accept, md_op stays MD_NONE, stall=0.
//  reset pulsed 3 cycles after DIV issue -> FSM IDLE then WAIT, since md_busy=1.
//  stall holds until md done, no second issue.
//  Force md_busy=1 permanently -> timeout=1 after 15 WAIT cycles, FSM IDLE.

Source files
------------

// File: rtl/md_issue_pkg.sv
// Shared md op encodings and widths used by the md issue controller and its users.
package md_issue_pkg;

  localparam int MD_OP_W = 4;

  localparam logic [MD_OP_W-1:0] MD_NONE  = 4'd0;
  localparam logic [MD_OP_W-1:0] MD_MULT  = 4'd1;
  localparam logic [MD_OP_W-1:0] MD_MULTU = 4'd2;
  localparam logic [MD_OP_W-1:0] MD_DIV   = 4'd3;
  localparam logic [MD_OP_W-1:0] MD_DIVU  = 4'd4;
  localparam logic [MD_OP_W-1:0] MD_MTHI  = 4'd5;
  localparam logic [MD_OP_W-1:0] MD_MTLO  = 4'd6;

endpackage

// File: rtl/md_issue_watchdog.sv
// md_watchdog: saturating up-counter with clear/enable and a terminal-count expire flag.
// Meant to be shared by multicycle units that need to bound a wait.
module md_watchdog
  import md_issue_pkg::*;
#(
  parameter int CNT_W = 4,
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [CNT_W-1:0] count;

  // Count enabled cycles since the last clear; hold at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  assign expire = (count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/md_issue.sv
// md_issue: EX-stage issue/interlock controller directly upstream of the md mul/div unit.
// Registers the op and operands toward md, stalls F/D/E while md is occupied, serves
// MFHI/MFLO from md's hi/lo, and keeps a sticky divide-by-zero flag and a watchdog timeout.
//
//   state | meaning
//   IDLE  | nothing in flight from this controller; an md op may be accepted
//   ISSUE | op is on md_op this cycle; md samples it on the negedge
//   WAIT  | md is busy; hold the pipeline until md finishes or the watchdog expires
module md_issue
  import md_issue_pkg::*;
#(
  parameter int OP_W    = MD_OP_W,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            e_valid,
  input  logic            e_flush,
  input  logic [OP_W-1:0] e_md_op,
  input  logic            e_mf_hi,
  input  logic            e_mf_lo,
  input  logic [31:0]     e_rs,
  input  logic [31:0]     e_rt,
  input  logic            md_busy,
  input  logic            md_invalid,
  input  logic [31:0]     md_hi,
  input  logic [31:0]     md_lo,
  output logic [OP_W-1:0] md_op,
  output logic [31:0]     md_dh,
  output logic [31:0]     md_dl,
  output logic            stall,
  output logic [31:0]     mf_data,
  output logic            div0_sticky,
  input  logic            div0_clr,
  output logic            timeout
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  state_e state, state_nxt;

  logic is_md_op;
  logic need;
  logic accept;
  logic div_q;
  logic first_wait;
  logic wd_clr;
  logic wd_en;
  logic wd_expire;

  assign is_md_op = (e_md_op != OP_W'(MD_NONE));
  assign need     = e_valid & ~e_flush & (is_md_op | e_mf_hi | e_mf_lo);
  assign stall    = need & ((state != ST_IDLE) | md_busy);
  assign accept   = (state == ST_IDLE) & ~md_busy & e_valid & ~e_flush & is_md_op;

  // Watchdog restarts on every entry into WAIT, whether from ISSUE or from a busy md in IDLE.
  assign wd_clr = (state_nxt == ST_WAIT) & (state != ST_WAIT);
  assign wd_en  = (state == ST_WAIT);

  md_watchdog #(
    .CNT_W (CNT_W),
    .LIMIT (TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clr    (wd_clr),
    .en     (wd_en),
    .expire (wd_expire)
  );

  // Next-state: md has no reset, so a busy md seen in IDLE must be waited out as well.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = ST_ISSUE;
        end else if (md_busy) begin
          state_nxt = ST_WAIT;
        end
      end
      ST_ISSUE: begin
        if ((md_op == OP_W'(MD_MTHI)) || (md_op == OP_W'(MD_MTLO))) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!md_busy || wd_expire) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State and issue registers; md_op is a one-cycle pulse, operands hold until the next accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      md_op      <= OP_W'(MD_NONE);
      md_dh      <= '0;
      md_dl      <= '0;
      div_q      <= 1'b0;
      first_wait <= 1'b0;
    end else begin
      state      <= state_nxt;
      md_op      <= accept ? e_md_op : OP_W'(MD_NONE);
      first_wait <= (state == ST_ISSUE) & (state_nxt == ST_WAIT);
      if (accept) begin
        md_dh <= e_rs;
        md_dl <= e_rt;
        div_q <= (e_md_op == OP_W'(MD_DIV)) | (e_md_op == OP_W'(MD_DIVU));
      end
    end
  end

  // Sticky flags: div0 is judged only in the first WAIT cycle of a divide, and a set beats a clear.
  // timeout records a real hang, i.e. the watchdog ran out with md still busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      div0_sticky <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      if (first_wait && div_q && md_invalid) begin
        div0_sticky <= 1'b1;
      end else if (div0_clr) begin
        div0_sticky <= 1'b0;
      end
      if ((state == ST_WAIT) && wd_expire && md_busy) begin
        timeout <= 1'b1;
      end
    end
  end

  // MFHI/MFLO read mux; hi takes priority when both are flagged.
  always_comb begin
    mf_data = '0;
    if (e_mf_hi) begin
      mf_data = md_hi;
    end else if (e_mf_lo) begin
      mf_data = md_lo;
    end
  end

endmodule
